// File: rtl/count_updown_pkg.sv
// Shared constants and helpers for the preloadable up/down event counter.
// The COUNT_SATURATE_EN option uses the limit constants defined here.
package count_updown_pkg;

    localparam int DEFAULT_WIDTH       = 16;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES     = 2;

    // Wide enough for any counter width; the top level slices down to WIDTH.
    localparam int MAX_WIDTH = 64;
    localparam logic [MAX_WIDTH-1:0] LIMIT_ALL_ONES = '1;
    localparam logic [MAX_WIDTH-1:0] LIMIT_ZERO     = '0;

    typedef enum logic [1:0] {
        OP_HOLD   = 2'd0,
        OP_UP     = 2'd1,
        OP_DOWN   = 2'd2,
        OP_CANCEL = 2'd3
    } update_op_e;

    function automatic update_op_e decode_op(input logic up, input logic dn);
        update_op_e op;
        case ({up, dn})
            2'b10:   op = OP_UP;
            2'b01:   op = OP_DOWN;
            2'b11:   op = OP_CANCEL;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/count_up_down_preload_edge_sync.sv
// Synchronizer chain plus registered rising-edge detector for one asynchronous strobe.
// Keeps sampling regardless of reset, so a level held across reset never looks like an edge.
module edge_sync
    import count_updown_pkg::*;
#(
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic async_in,
    output logic pulse_out
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;
    logic              hist_reg;
    logic              pulse_reg;
    logic              pulse_next;

    assign sync_next[0] = async_in;

    genvar gi;
    generate
        for (gi = 1; gi < STAGES; gi++) begin : g_chain
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    assign pulse_next = sync_reg[STAGES-1] & ~hist_reg;

    // The pulse is registered so the count changes SYNC_STAGES+1 edges after first sample.
    always_ff @(posedge clk) begin
        sync_reg  <= sync_next;
        hist_reg  <= sync_reg[STAGES-1];
        pulse_reg <= pulse_next;
    end

    assign pulse_out = pulse_reg;

endmodule

// File: rtl/count_up_down_preload.sv
// Preloadable up/down event counter with programmable unsigned step.
// Define COUNT_SATURATE_EN to clamp at all-ones / zero instead of wrapping.
module count_up_down_preload
    import count_updown_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_up,
    input  logic             clk_dn,
    input  logic [WIDTH-1:0] preload,
    input  logic [WIDTH-1:0] increment,
    output logic [WIDTH-1:0] count
);

    logic             up_pulse;
    logic             dn_pulse;
    logic             blocked_reg;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] add_result;
    logic [WIDTH-1:0] sub_result;
    update_op_e       op;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_up (
        .clk       (clk),
        .async_in  (clk_up),
        .pulse_out (up_pulse)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dn (
        .clk       (clk),
        .async_in  (clk_dn),
        .pulse_out (dn_pulse)
    );

`ifdef COUNT_SATURATE_EN
    logic [WIDTH:0] sum_ext;
    logic [WIDTH:0] diff_ext;

    // Carry out of the sum means overflow; borrow out of the difference means underflow.
    always_comb begin
        sum_ext    = {1'b0, count_reg} + {1'b0, increment};
        diff_ext   = {1'b0, count_reg} - {1'b0, increment};
        add_result = sum_ext[WIDTH]  ? LIMIT_ALL_ONES[WIDTH-1:0] : sum_ext[WIDTH-1:0];
        sub_result = diff_ext[WIDTH] ? LIMIT_ZERO[WIDTH-1:0]     : diff_ext[WIDTH-1:0];
    end
`else
    always_comb begin
        add_result = count_reg + increment;
        sub_result = count_reg - increment;
    end
`endif

    // blocked_reg masks pulses that were detected on a reset cycle.
    always_comb begin
        op         = decode_op(up_pulse & ~blocked_reg, dn_pulse & ~blocked_reg);
        count_next = count_reg;
        case (op)
            OP_UP:   count_next = add_result;
            OP_DOWN: count_next = sub_result;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg   <= preload;
            blocked_reg <= 1'b1;
        end else begin
            count_reg   <= count_next;
            blocked_reg <= 1'b0;
        end
    end

    assign count = count_reg;

endmodule

// File: tb/tb_count_up_down_preload.sv
// Self-checking bench for count_up_down_preload: directed sequences, a vector table,
// and randomized event slots checked against an arithmetic reference model.
module tb_count_up_down_preload;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         clk_up;
    logic         clk_dn;
    logic [W-1:0] preload;
    logic [W-1:0] increment;
    logic [W-1:0] count;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    count_up_down_preload #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_up    (clk_up),
        .clk_dn    (clk_dn),
        .preload   (preload),
        .increment (increment),
        .count     (count)
    );

    typedef struct {
        string        name;
        logic [W-1:0] pre;
        logic [W-1:0] inc;
        logic         up;
        logic         dn;
        logic [W-1:0] exp_wrap;
        logic [W-1:0] exp_sat;
    } vec_t;

    vec_t vecs [7];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
            $display("check %-22s count=%h expected=%h ok", name, act, exp);
        end else begin
            $display("FAIL %s: count=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset(input logic [W-1:0] p, input logic [W-1:0] inc, input int n);
        reset     = 1'b1;
        preload   = p;
        increment = inc;
        cyc(n);
        reset = 1'b0;
    endtask

    task automatic pulse(input logic up, input logic dn, input int hi, input int lo);
        clk_up = up;
        clk_dn = dn;
        cyc(hi);
        clk_up = 1'b0;
        clk_dn = 1'b0;
        cyc(lo);
    endtask

    // Reference: net signed change applied with plain integer arithmetic.
    function automatic logic [W-1:0] model_apply(input logic [W-1:0] c, input logic [W-1:0] inc,
                                                 input int up, input int dn);
        longint v;
        logic [63:0] r;
        v = longint'(c) + longint'(up - dn) * longint'(inc);
`ifdef COUNT_SATURATE_EN
        if (v > 65535) v = 65535;
        if (v < 0) v = 0;
`else
        v = ((v % 65536) + 65536) % 65536;
`endif
        r = 64'(v);
        return r[W-1:0];
    endfunction

    initial begin
        logic [W-1:0] model;
        logic [W-1:0] exp;
        int up, dn, hi;

        vecs[0] = '{"cancel_both",   16'd1000, 16'd25,   1'b1, 1'b1, 16'd1000, 16'd1000};
        vecs[1] = '{"wrap_up",       16'hFFF0, 16'h0020, 1'b1, 1'b0, 16'h0010, 16'hFFFF};
        vecs[2] = '{"wrap_down",     16'h0010, 16'h0020, 1'b0, 1'b1, 16'hFFF0, 16'h0000};
        vecs[3] = '{"increment_zero",16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1234, 16'h1234};
        vecs[4] = '{"max_plus_one",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'hFFFF};
        vecs[5] = '{"down_to_zero",  16'h0020, 16'h0020, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[6] = '{"plain_up",      16'h0100, 16'h0003, 1'b1, 1'b0, 16'h0103, 16'h0103};

        reset     = 1'b1;
        clk_up    = 1'b0;
        clk_dn    = 1'b0;
        preload   = 16'd1000;
        increment = 16'd25;

        // Reset loads preload from the first edge and tracks it
        cyc(1);
        check("reset_first_edge", count, 16'd1000);
        preload = 16'd500;
        cyc(1);
        check("reset_tracks_preload", count, 16'd500);
        preload = 16'd1000;
        cyc(8);
        check("reset_end", count, 16'd1000);
        reset = 1'b0;
        cyc(3);
        check("after_release", count, 16'd1000);

        // Latency: update lands on the third edge after first sample
        clk_up = 1'b1;
        cyc(3);
        check("latency_hold", count, 16'd1000);
        cyc(1);
        check("latency_update", count, 16'd1025);
        cyc(1);
        clk_up = 1'b0;
        cyc(10);
        check("single_up_long_pulse", count, 16'd1025);
        pulse(1'b1, 1'b0, 5, 10);
        check("second_up", count, 16'd1050);
        pulse(1'b0, 1'b1, 5, 10);
        check("single_down", count, 16'd1025);

        // Edge entirely inside reset is discarded
        reset = 1'b1;
        cyc(2);
        clk_up = 1'b1;
        cyc(3);
        clk_up = 1'b0;
        cyc(6);
        reset = 1'b0;
        cyc(10);
        check("edge_during_reset", count, 16'd1000);

        // Level held high across reset release makes no event
        reset = 1'b1;
        cyc(2);
        clk_up = 1'b1;
        cyc(5);
        reset = 1'b0;
        cyc(8);
        check("level_across_release", count, 16'd1000);
        clk_up = 1'b0;
        cyc(4);
        check("level_fall_no_event", count, 16'd1000);

        // Reset asserted while an event is in flight drops it
        clk_up = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(3);
        clk_up = 1'b0;
        reset  = 1'b0;
        cyc(8);
        check("reset_mid_latency", count, 16'd1000);

        // Table of boundary vectors
        for (int i = 0; i < 7; i++) begin
            do_reset(vecs[i].pre, vecs[i].inc, 3);
            cyc(2);
            pulse(vecs[i].up, vecs[i].dn, 3, 8);
`ifdef COUNT_SATURATE_EN
            exp = vecs[i].exp_sat;
`else
            exp = vecs[i].exp_wrap;
`endif
            check(vecs[i].name, count, exp);
        end

        // Randomized slots against the reference model
        do_reset(16'($urandom), 16'($urandom_range(0, 300)), 3);
        cyc(2);
        model = preload;
        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                do_reset(16'($urandom), increment, 3);
                cyc(2);
                model = preload;
                check("rand_reset", count, model);
            end else begin
                if ($urandom_range(0, 3) == 0) increment = 16'($urandom);
                else                           increment = 16'($urandom_range(0, 300));
                up = int'($urandom_range(0, 1));
                dn = int'($urandom_range(0, 1));
                hi = int'($urandom_range(2, 4));
                pulse(up[0], dn[0], hi, 6);
                model = model_apply(model, increment, up, dn);
                check("rand_slot", count, model);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/count_up_down_preload.md
# count_up_down_preload

Preloadable up/down event counter with a programmable step. It sits downstream of pulse-generating timing logic. Asynchronous rising edges on `clk_up` and `clk_dn` are synchronized into the single system clock domain. Each accepted edge adds `increment` to `count` (up) or subtracts it (down). Synchronous reset loads `count` from `preload`.

## Interface
- One clock; reset is synchronous and active-high.
- Parameters:
  - `WIDTH`, 16: width of `preload`, `increment` and `count`.
  - `SYNC_STAGES`, 2: synchronizer flops per event input; minimum 2.
- Ports:
  - `clk`, input, 1: system clock; all state updates on its rising edge.
  - `reset`, input, 1: synchronous, active-high; loads preload and blocks events.
  - `clk_up`, input, 1: asynchronous up-event strobe; its rising edge counts.
  - `clk_dn`, input, 1: asynchronous down-event strobe; its rising edge counts.
  - `preload`, input, WIDTH: value loaded into `count` during reset.
  - `increment`, input, WIDTH: step size, applied unsigned.
  - `count`, output, WIDTH: registered counter value.

## Operation
- Reset value of `count`: `preload`, loaded on every `clk` edge while `reset`=1, so it tracks `preload` changes during reset.
- Event path, per input:
  - `SYNC_STAGES`-flop synchronizer, then one history flop.
  - Event pulse = last sync stage high AND history flop low; the pulse is one `clk` cycle wide.
- Synchronizer and history flops keep sampling during reset.
  - Edges detected while `reset`=1 are discarded.
  - A level held high across reset release produces no event.
- Per `clk` edge with `reset`=0:
  - up pulse only: `count <= count + increment`.
  - down pulse only: `count <= count - increment`.
  - both pulses in the same cycle: `count` unchanged; the events cancel.
  - neither: `count` holds.
- `increment` is sampled on the cycle the update occurs.
- Arithmetic is modulo 2^WIDTH (wrap-around) unless saturation is compiled in (see Configuration).
- `increment`=0: events are accepted but `count` does not change.

## Timing
- Latency: for a `clk_up`/`clk_dn` level first sampled high at edge N, `count` updates at edge N+SYNC_STAGES+1 (N+3 by default).
- Input strobes must be high ≥2 `clk` periods and low ≥2 `clk` periods between edges. Narrower pulses may be missed.
- One update per qualifying rising edge, regardless of pulse length.
- Reset asserted mid-latency: a pending event is dropped; the first cycle of reset loads `preload`.
- Reset release: the first event can update `count` on the edge after the first cycle with `reset`=0, provided the edge is detected then.

## Configuration
- `COUNT_SATURATE_EN`, when defined:
  - Up saturates at 2^WIDTH-1; down saturates at 0.
  - Overflow and underflow are detected from the WIDTH+1-bit sum or difference.
- Without `COUNT_SATURATE_EN`: plain modulo wrap-around.

## Structure
- Shared package `count_updown_pkg` holds:
  - default `WIDTH` (16) and default `SYNC_STAGES` (2);
  - the all-ones and zero limit constants used by saturation.
- Sub-module `edge_sync`:
  - parameter `SYNC_STAGES`;
  - ports `clk`, `async_in`, `pulse_out`;
  - synchronizer plus rising-edge detector, instantiated once for `clk_up` and once for `clk_dn`.
- Top level holds the count register, the update priority logic and the saturation option.

## Test plan
- Reset loads preload: `preload`=1000, `increment`=25, `reset` high 10 cycles → `count`=1000 from the first reset edge; still 1000 after release.
- Up events: `clk_up` high 5 cycles, then low 10 cycles → exactly one update to 1025, SYNC_STAGES+1 edges after sampling. A second pulse → 1050.
- Down event: `clk_dn` pulse from 1050 → 1025. A 5-cycle pulse yields a single decrement.
- Edge during reset: assert `reset`, pulse `clk_up` inside it, release → `count`=1000 and no increment after release.
- Simultaneous events: `clk_up` and `clk_dn` rising on the same `clk` edge from 1000 → `count` stays 1000.
- Wrap or saturate:
  - `preload`=16'hFFF0, `increment`=16'h0020, up → 16'h0010 (wrap) or 16'hFFFF with `COUNT_SATURATE_EN`.
  - `preload`=16'h0010, down → 16'hFFF0 (wrap) or 16'h0000 with `COUNT_SATURATE_EN`.
